fifo_arb_tx: RTL

- Packet-atomic 2:1 arbiter, the transmit-side counterpart of fifo_arb_rx.
- Drains two source FIFOs (ch0, ch1) into a single host-bound sink FIFO, one complete packet at a time.
- A packet is one command word followed by L payload words, where L = host_fifo_pkg::fifo_payload((cmd >> CNT_SHIFT) & CNT_MASK).
- Round-robin between channels at packet boundaries, so words from the two channels never interleave inside a packet.

---
 rtl/host_fifo_pkg.sv | 33 +++
 rtl/fifo_arb_tx_skid2.sv | 41 ++++
 rtl/fifo_arb_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/host_fifo_pkg.sv
// Shared host FIFO helpers: payload-length decode and the packet arbiter state encoding.
package host_fifo_pkg;

    localparam int unsigned FIFO_PAYLOAD_WIDTH = 8;
    // One extra bit so the largest decodable length never wraps the countdown.
    localparam int unsigned REM_W = FIFO_PAYLOAD_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        PAYLOAD,
        DONE
    } arb_state_t;

    // Payload words that follow a command carrying this count field.
    function automatic logic [FIFO_PAYLOAD_WIDTH-1:0] fifo_payload(
        input logic [FIFO_PAYLOAD_WIDTH-1:0] field
    );
        return field;
    endfunction

    // Decode payload length straight from a command word.
    function automatic logic [REM_W-1:0] cmd_len(
        input logic [63:0]  cmd,
        input int unsigned  shift,
        input logic [63:0]  mask
    );
        logic [63:0] field;
        field = (cmd >> shift) & mask;
        return REM_W'(fifo_payload(FIFO_PAYLOAD_WIDTH'(field)));
    endfunction

endpackage

// File: rtl/fifo_arb_tx_skid2.sv
// Two-entry skid buffer catching source read data on its one-cycle return path.
module fifo_arb_tx_skid2 #(
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];
    assign occ  = count;

endmodule

// File: rtl/fifo_arb_tx.sv
// Packet-atomic 2:1 arbiter draining two source FIFOs into one host-bound sink FIFO.
module fifo_arb_tx
    import host_fifo_pkg::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned CNT_SHIFT  = 16,
    parameter logic [31:0] CNT_MASK   = 32'hFF,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    output logic          c0_rd_en_o,
    input  logic [DW-1:0] c0_rd_data_i,
    input  logic          c0_empty_i,
    output logic          c1_rd_en_o,
    input  logic [DW-1:0] c1_rd_data_i,
    input  logic          c1_empty_i,
    output logic          wr_en_o,
    output logic [DW-1:0] wr_data_o,
    input  logic          full_i,
    output logic [1:0]    grant_o,
    output logic          busy_o
);

    localparam int unsigned OCC_W = 3;

    arb_state_t       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             rr_prio_q, rr_prio_d;
    logic             cmd_issued_q, cmd_issued_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [REM_W-1:0] cmd_len_w;
    logic             inflight_q;

    logic             rd_issue;
    logic             src_empty;
    logic             slots_ok;
    logic             pick0, pick1;
    logic             push, pop;
    logic [DW-1:0]    push_data;
    logic [DW-1:0]    head;
    logic [1:0]       occ;

    fifo_arb_tx_skid2 #(.DW(DW)) u_skid (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    // Grant is frozen for the whole packet, so it also steers the return data.
    assign src_empty = grant_q[1] ? c1_empty_i : c0_empty_i;
    assign push      = inflight_q;
    assign push_data = grant_q[1] ? c1_rd_data_i : c0_rd_data_i;
    assign pop       = (occ != 2'd0) && !full_i;
    assign slots_ok  = (OCC_W'(occ) + OCC_W'(inflight_q) - OCC_W'(pop)) < OCC_W'(2);

    // rr_prio_q = 1 means ch1 is preferred when both channels hold data.
    always_comb begin
        pick0 = 1'b0;
        if (FIXED_PRIO || !rr_prio_q) begin
            pick0 = !c0_empty_i;
        end else begin
            pick0 = !c0_empty_i && c1_empty_i;
        end
        pick1 = !c1_empty_i && !pick0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        rr_prio_d    = rr_prio_q;
        cmd_issued_d = cmd_issued_q;
        rem_d        = rem_q;
        rd_issue     = 1'b0;
        cmd_len_w    = cmd_len(64'(push_data), CNT_SHIFT, 64'(CNT_MASK));
        case (state_q)
            IDLE: begin
                cmd_issued_d = 1'b0;
                if (pick0 || pick1) begin
                    grant_d = {pick1, pick0};
                    busy_d  = 1'b1;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (!cmd_issued_q) begin
                    rd_issue     = !src_empty && slots_ok;
                    cmd_issued_d = rd_issue;
                end else if (inflight_q) begin
                    // First payload read goes out in the command's arrival cycle.
                    if (cmd_len_w == '0) begin
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        rd_issue = !src_empty && slots_ok;
                        rem_d    = cmd_len_w - REM_W'(rd_issue);
                        state_d  = (rem_d == '0) ? DONE : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if ((rem_q != '0) && !src_empty && slots_ok) begin
                    rd_issue = 1'b1;
                    rem_d    = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if ((occ == 2'd0) && !inflight_q) begin
                    rr_prio_d = grant_q[0];
                    grant_d   = 2'b00;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            rr_prio_q    <= 1'b0;
            cmd_issued_q <= 1'b0;
            rem_q        <= '0;
            inflight_q   <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            rr_prio_q    <= rr_prio_d;
            cmd_issued_q <= cmd_issued_d;
            rem_q        <= rem_d;
            inflight_q   <= rd_issue;
        end
    end

    assign c0_rd_en_o = rd_issue && grant_q[0];
    assign c1_rd_en_o = rd_issue && grant_q[1];
    assign wr_en_o    = pop;
    assign wr_data_o  = head;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;

endmodule
